// File: rtl/mips_mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath that consumes the strobes.
interface mips_mc_ctrl_fsm_if #(
  parameter int ALU_CTRL_WIDTH = 3
);
  logic [5:0]                Op;
  logic [5:0]                Funct;
  logic                      Zero;
  logic                      mem_ready;
  logic                      PC_En;
  logic                      I_or_D;
  logic                      Mem_Read;
  logic                      Mem_Write;
  logic                      IR_Write;
  logic                      Reg_Dst;
  logic                      Mem_to_Reg;
  logic                      Reg_Write;
  logic                      ALU_Src_A;
  logic [1:0]                ALU_Src_B;
  logic [ALU_CTRL_WIDTH-1:0] ALU_Control;
  logic [1:0]                PC_Src;
  logic                      Illegal;
  logic                      Timeout;
  logic [3:0]                State;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PC_En, I_or_D, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
           Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, Illegal, Timeout, State
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PC_En, I_or_D, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
           Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, Illegal, Timeout, State
  );
endinterface

// File: rtl/mips_mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory wait states, access timeout and sticky traps.
// Define MC_CTRL_BNE_EN to decode opcode 0x05 (bne); otherwise it traps as illegal.
module mips_mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT    = 15,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  mips_mc_ctrl_fsm_if.master  bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPEEX = 4'd6, S_ALUWB  = 4'd7,
    S_BEQEX   = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
    S_BNEEX   = 4'd12, S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal, timeout;
  logic             set_illegal, set_timeout;
  logic             mem_state, mem_expired;
  logic             funct_ok;
  logic [2:0]       funct_alu;

  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  assign mem_state   = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  // A zero MEM_TIMEOUT lets an access wait forever.
  assign mem_expired = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.Funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // NOTE: every output and next-state signal gets a default first so no path infers a latch.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = ALU_AND;
    pc_src      = 2'b00;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          state_next = S_DECODE;
        end else if (mem_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (bus.Op)
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default: begin
            set_illegal = 1'b1;
            state_next  = S_TRAP;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        if (state == S_ADDIEX) state_next = S_ADDIWB;
        else                   state_next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD, S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_read  = (state == S_MEMRD);
        mem_write = (state == S_MEMWR);
        if (bus.mem_ready) begin
          state_next = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (mem_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        if (funct_ok) begin
          state_next = S_ALUWB;
        end else begin
          set_illegal = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_ALUWB, S_ADDIWB: begin
        reg_write  = 1'b1;
        reg_dst    = (state == S_ALUWB);
        state_next = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = (state == S_BEQEX) ? bus.Zero : !bus.Zero;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
      // The counter restarts whenever the FSM moves, so it only counts stalls of one access.
      if (state_next != state)             wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_En       = pc_en;
  assign bus.I_or_D      = i_or_d;
  assign bus.Mem_Read    = mem_read;
  assign bus.Mem_Write   = mem_write;
  assign bus.IR_Write    = ir_write;
  assign bus.Reg_Dst     = reg_dst;
  assign bus.Mem_to_Reg  = mem_to_reg;
  assign bus.Reg_Write   = reg_write;
  assign bus.ALU_Src_A   = alu_src_a;
  assign bus.ALU_Src_B   = alu_src_b;
  assign bus.ALU_Control = ALU_CTRL_WIDTH'(alu_ctrl);
  assign bus.PC_Src      = pc_src;
  assign bus.Illegal     = illegal;
  assign bus.Timeout     = timeout;
  assign bus.State       = state;

endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
// Bench for mips_mc_ctrl_fsm: directed scenarios plus randomized instructions and wait states
// checked against an instruction-level model of expected state walks and strobes.
module tb_mips_mc_ctrl_fsm;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_mc_ctrl_fsm_if #(.ALU_CTRL_WIDTH(3)) bus ();
  mips_mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .ALU_CTRL_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pc_en, i_or_d, mem_rd, mem_wr, ir_wr, reg_dst, m2r, reg_wr, src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
  } out_t;

  typedef struct {
    int st;
    bit rdy;
    bit ill;
    bit to;
  } step_t;

  step_t plan[$];

  function automatic out_t get_act();
    out_t o;
    o.pc_en  = bus.PC_En;     o.i_or_d = bus.I_or_D;   o.mem_rd = bus.Mem_Read;
    o.mem_wr = bus.Mem_Write; o.ir_wr  = bus.IR_Write; o.reg_dst = bus.Reg_Dst;
    o.m2r    = bus.Mem_to_Reg; o.reg_wr = bus.Reg_Write; o.src_a = bus.ALU_Src_A;
    o.src_b  = bus.ALU_Src_B; o.alu    = bus.ALU_Control; o.pc_src = bus.PC_Src;
    return o;
  endfunction

  function automatic void funct_alu(input logic [5:0] f, output bit ok, output logic [2:0] a);
    ok = 1'b1;
    case (f)
      6'h20: a = 3'b010;
      6'h22: a = 3'b110;
      6'h24: a = 3'b000;
      6'h25: a = 3'b001;
      6'h2A: a = 3'b111;
      default: begin ok = 1'b0; a = 3'b000; end
    endcase
  endfunction

  // Expected value and care mask per state; true strobes are always compared.
  function automatic void exp_out(input int st, input bit rdy, input bit z, input logic [5:0] f,
                                  output out_t e, output out_t m);
    bit ok;
    logic [2:0] fa;
    e = '0;
    m = '0;
    m.pc_en = 1; m.i_or_d = 1; m.mem_rd = 1; m.mem_wr = 1; m.ir_wr = 1; m.reg_wr = 1;
    case (st)
      0: begin
        e.mem_rd = 1; e.pc_en = rdy; e.ir_wr = rdy; e.src_b = 2'b01; e.alu = 3'b010;
        m.src_a = 1; m.src_b = '1; m.alu = '1; m.pc_src = '1;
      end
      1: begin e.src_b = 2'b11; e.alu = 3'b010; m.src_b = '1; m.alu = '1; end
      2, 9: begin
        e.src_a = 1; e.src_b = 2'b10; e.alu = 3'b010;
        m.src_a = 1; m.src_b = '1; m.alu = '1;
      end
      3: begin e.i_or_d = 1; e.mem_rd = 1; end
      4: begin e.reg_wr = 1; e.m2r = 1; m.reg_dst = 1; m.m2r = 1; end
      5: begin e.i_or_d = 1; e.mem_wr = 1; end
      6: begin
        e.src_a = 1; m.src_a = 1; m.src_b = '1;
        funct_alu(f, ok, fa);
        if (ok) begin e.alu = fa; m.alu = '1; end
      end
      7: begin e.reg_wr = 1; e.reg_dst = 1; m.reg_dst = 1; m.m2r = 1; end
      10: begin e.reg_wr = 1; m.reg_dst = 1; m.m2r = 1; end
      8, 12: begin
        e.src_a = 1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = (st == 8) ? z : !z;
        m.src_a = 1; m.src_b = '1; m.alu = '1; m.pc_src = '1;
      end
      11: begin e.pc_src = 2'b10; e.pc_en = 1; m.pc_src = '1; end
      default: m = '1;
    endcase
  endfunction

  function automatic void push(input int st, input bit rdy, input bit ill, input bit to);
    step_t s;
    s.st = st; s.rdy = rdy; s.ill = ill; s.to = to;
    plan.push_back(s);
  endfunction

  // A memory access stalls w cycles; the timeout fires after TMO+1 consecutive stalls.
  function automatic bit add_mem(input int st, input int w);
    int lim = (TMO == 0) ? 32'h4000_0000 : TMO + 1;
    int n0  = (w < lim) ? w : lim;
    for (int i = 0; i < n0; i++) push(st, 1'b0, 1'b0, 1'b0);
    if (w >= lim) begin
      push(15, 1'b0, 1'b0, 1'b1);
      return 1'b1;
    end
    push(st, 1'b1, 1'b0, 1'b0);
    return 1'b0;
  endfunction

  function automatic void build_plan(input logic [5:0] op, input logic [5:0] f,
                                     input int wf, input int wm);
    bit ok, tr;
    logic [2:0] fa;
    plan.delete();
    if (add_mem(0, wf)) return;
    push(1, 1'($urandom), 1'b0, 1'b0);
    case (op)
      6'h00: begin
        push(6, 1'($urandom), 1'b0, 1'b0);
        funct_alu(f, ok, fa);
        if (ok) push(7, 1'($urandom), 1'b0, 1'b0);
        else    push(15, 1'b0, 1'b1, 1'b0);
      end
      6'h23: begin
        push(2, 1'($urandom), 1'b0, 1'b0);
        tr = add_mem(3, wm);
        if (!tr) push(4, 1'($urandom), 1'b0, 1'b0);
      end
      6'h2B: begin
        push(2, 1'($urandom), 1'b0, 1'b0);
        tr = add_mem(5, wm);
      end
      6'h04: push(8, 1'($urandom), 1'b0, 1'b0);
      6'h08: begin
        push(9, 1'($urandom), 1'b0, 1'b0);
        push(10, 1'($urandom), 1'b0, 1'b0);
      end
      6'h02: push(11, 1'($urandom), 1'b0, 1'b0);
`ifdef MC_CTRL_BNE_EN
      6'h05: push(12, 1'($urandom), 1'b0, 1'b0);
`endif
      default: push(15, 1'b0, 1'b1, 1'b0);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit z);
    bus.mem_ready = rdy;
    bus.Zero      = z;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    out_t e;
    reset = 1'b0;
    bus.Op = 6'h00; bus.Funct = 6'h20; bus.mem_ready = 1'b0; bus.Zero = 1'b0;
    #3;
    e = '0; e.mem_rd = 1; e.src_b = 2'b01; e.alu = 3'b010;
    checks++;
    if (bus.State !== 4'd0 || bus.Illegal !== 1'b0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d ill=%b to=%b exp st=0 ill=0 to=0",
               bus.State, bus.Illegal, bus.Timeout);
    end
    checks++;
    if (get_act() !== e) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", get_act(), e);
    end
    do_reset();
  endtask

  task automatic test_lw();
    int seq[6] = '{0, 1, 2, 3, 4, 0};
    bus.Op = 6'h23;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'($urandom));
      checks++;
      if (bus.State !== 4'(seq[i])) begin
        errors++;
        $display("FAIL lw_state cycle %0d got %0d exp %0d", i, bus.State, seq[i]);
      end
      if (i == 4) begin
        checks++;
        if (bus.Reg_Write !== 1'b1 || bus.Mem_to_Reg !== 1'b1) begin
          errors++;
          $display("FAIL lw_wb got rw=%b m2r=%b exp 1 1", bus.Reg_Write, bus.Mem_to_Reg);
        end
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw_wait();
    bus.Op = 6'h2B;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 1'b0);
      checks++;
      if (bus.State !== 4'd5 || bus.Mem_Write !== 1'b1) begin
        errors++;
        $display("FAIL sw_wait cycle %0d got st=%0d mw=%b exp st=5 mw=1", i, bus.State, bus.Mem_Write);
      end
      tick();
    end
    drive(1'b0, 1'b0);
    checks++;
    if (bus.State !== 4'd0 || bus.Illegal !== 1'b0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL sw_done got st=%0d ill=%b to=%b exp 0 0 0", bus.State, bus.Illegal, bus.Timeout);
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      bit z = (k == 0);
      bus.Op = 6'h04;
      drive(1'b1, 1'b0); tick();
      drive(1'b1, 1'b0); tick();
      drive(1'($urandom), z);
      checks++;
      if (bus.State !== 4'd8 || bus.PC_En !== z || bus.PC_Src !== 2'b01) begin
        errors++;
        $display("FAIL beq_z%0d got st=%0d pc_en=%b pc_src=%b exp st=8 pc_en=%b pc_src=01",
                 z, bus.State, bus.PC_En, bus.PC_Src, z);
      end
      tick();
    end
  endtask

  task automatic test_rtype();
    bus.Op = 6'h00; bus.Funct = 6'h2A;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0);
    checks++;
    if (bus.State !== 4'd6 || bus.ALU_Control !== 3'b111) begin
      errors++;
      $display("FAIL rtype_slt got st=%0d alu=%b exp st=6 alu=111", bus.State, bus.ALU_Control);
    end
    tick(); drive(1'b0, 1'b0);
    checks++;
    if (bus.State !== 4'd7 || bus.Reg_Dst !== 1'b1 || bus.Reg_Write !== 1'b1) begin
      errors++;
      $display("FAIL rtype_wb got st=%0d rd=%b rw=%b exp st=7 rd=1 rw=1", bus.State, bus.Reg_Dst, bus.Reg_Write);
    end
    tick();
    bus.Funct = 6'h3F;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (bus.State !== 4'd15 || bus.Illegal !== 1'b1 || get_act() !== '0) begin
        errors++;
        $display("FAIL rtype_trap cycle %0d got st=%0d ill=%b out=%h exp st=15 ill=1 out=0",
                 i, bus.State, bus.Illegal, get_act());
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (bus.State !== 4'd0) begin
        errors++;
        $display("FAIL timeout_wait cycle %0d got st=%0d exp 0", i, bus.State);
      end
      tick();
    end
    drive(1'b0, 1'b0);
    checks++;
    if (bus.State !== 4'd15 || bus.Timeout !== 1'b1 || bus.Illegal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_trap got st=%0d to=%b ill=%b exp 15 1 0", bus.State, bus.Timeout, bus.Illegal);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.State !== 4'd0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got st=%0d to=%b exp 0 0", bus.State, bus.Timeout);
    end
    do_reset();
  endtask

  task automatic test_bne();
    bus.Op = 6'h05;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0);
    checks++;
`ifdef MC_CTRL_BNE_EN
    if (bus.State !== 4'd12 || bus.PC_En !== 1'b1) begin
      errors++;
      $display("FAIL bne_taken got st=%0d pc_en=%b exp 12 1", bus.State, bus.PC_En);
    end
    tick();
`else
    if (bus.State !== 4'd15 || bus.Illegal !== 1'b1) begin
      errors++;
      $display("FAIL bne_illegal got st=%0d ill=%b exp 15 1", bus.State, bus.Illegal);
    end
    do_reset();
`endif
  endtask

  task automatic test_reset_mid_write();
    bus.Op = 6'h2B;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.Mem_Write !== 1'b0 || bus.State !== 4'd0 || bus.Mem_Read !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_write got mw=%b st=%0d mr=%b exp 0 0 1", bus.Mem_Write, bus.State, bus.Mem_Read);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops[9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05, 6'h00, 6'h23};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, f;
      int wf, wm;
      out_t e, m, a;
      bit z;
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      f  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 4);
      build_plan(op, f, wf, wm);
      if (plan[$].st == 15) plan.push_back(plan[$]);
      bus.Op = op;
      bus.Funct = f;
      for (int k = 0; k < plan.size(); k++) begin
        z = 1'($urandom);
        drive(plan[k].rdy, z);
        exp_out(plan[k].st, plan[k].rdy, z, f, e, m);
        a = get_act();
        checks++;
        if (bus.State !== 4'(plan[k].st)) begin
          errors++;
          $display("FAIL rand_state instr %0d op %h step %0d got %0d exp %0d",
                   n, op, k, bus.State, plan[k].st);
        end
        checks++;
        if (((a ^ e) & m) !== '0) begin
          errors++;
          $display("FAIL rand_outputs instr %0d op %h step %0d got %h exp %h mask %h",
                   n, op, k, a, e, m);
        end
        checks++;
        if (bus.Illegal !== plan[k].ill || bus.Timeout !== plan[k].to) begin
          errors++;
          $display("FAIL rand_flags instr %0d step %0d got ill=%b to=%b exp ill=%b to=%b",
                   n, k, bus.Illegal, bus.Timeout, plan[k].ill, plan[k].to);
        end
        tick();
      end
      if (plan[$].st == 15) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_rtype();
    test_timeout();
    test_bne();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl_fsm.md
# mips_mc_ctrl_fsm

Parametrised multi-cycle MIPS control unit: a next-generation replacement for the processor's control FSM, wired between the instruction register opcode/funct fields and the 32-bit datapath. Over the base controller it adds a memory ready handshake with wait states, a programmable memory timeout, internal branch resolution from the ALU Zero flag, jump support, and a sticky trap for illegal instructions. All datapath strobes come from this block; the datapath computes nothing about control.

## Interface
- MEM_TIMEOUT, 15: max wait cycles for mem_ready per access; 0 disables the timeout.
- ALU_CTRL_WIDTH, 3: width of ALU_Control; values above 3 zero-extend the encodings below.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  6  instruction opcode field.
- Funct  in  6  instruction funct field.
- Zero  in  1  ALU zero flag, valid in branch states.
- mem_ready  in  1  memory access complete this cycle.
- PC_En  out  1  PC register load enable.
- I_or_D  out  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Read / Mem_Write  out  1 each  memory strobes.
- IR_Write  out  1  instruction register load.
- Reg_Dst  out  1  write register select: 1 = rd, 0 = rt.
- Mem_to_Reg  out  1  write-back select: 1 = data register.
- Reg_Write  out  1  register file write enable.
- ALU_Src_A  out  1  0 = PC, 1 = register A.
- ALU_Src_B  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- ALU_Control  out  ALU_CTRL_WIDTH  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PC_Src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  sticky: an undecodable instruction was fetched.
- Timeout  out  1  sticky: a memory access exceeded MEM_TIMEOUT.
- State  out  4  current state code, for debug.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12, TRAP 15.
- FETCH: Mem_Read=1, I_or_D=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Control=add, PC_Src=00.
  - Holds until mem_ready=1.
  - In that cycle only, IR_Write=1 and PC_En=1, then go to DECODE.
- DECODE: ALU_Src_B=11 with add, to compute the branch target.
  - Op 0x00 -> RTYPEEX; 0x23 or 0x2B -> MEMADR; 0x04 -> BEQEX; 0x08 -> ADDIEX; 0x02 -> JEX.
  - Any other Op -> TRAP.
- MEMADR: ALU_Src_A=1, ALU_Src_B=10, add. Op 0x23 -> MEMRD, else MEMWR.
- MEMRD: I_or_D=1, Mem_Read=1. Waits for mem_ready, then MEMWB.
- MEMWR: I_or_D=1, Mem_Write=1 held while waiting. Goes to FETCH on mem_ready.
- MEMWB: Reg_Write=1, Mem_to_Reg=1, Reg_Dst=0.
- RTYPEEX: ALU_Src_A=1, ALU_Src_B=00. ALU_Control is decoded from Funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other Funct -> TRAP. Otherwise go to ALUWB.
- ALUWB: Reg_Write=1, Reg_Dst=1, Mem_to_Reg=0.
- ADDIEX: ALU_Src_A=1, ALU_Src_B=10, add. Then ADDIWB, which is ALUWB with Reg_Dst=0.
- BEQEX: ALU_Src_A=1, ALU_Src_B=00, sub, PC_Src=01, PC_En=Zero.
- BNEEX: same as BEQEX but PC_En=~Zero.
- JEX: PC_Src=10, PC_En=1.
- Writeback, branch and jump states all return to FETCH.
- TRAP: every strobe is 0 and the FSM stays there until reset. Illegal is set on entry from decode; Timeout is set on entry via timeout.
- Wait counter:
  - Clears on entry to any memory state and increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 (MEM_TIMEOUT≠0), go to TRAP next cycle.
  - Counter width is clog2(MEM_TIMEOUT+1).

## Timing
- Outputs are combinational from State. PC_En and IR_Write also depend on mem_ready or Zero.
- Reset values (reset low, asynchronous):
  - State=FETCH, Illegal=0, Timeout=0, counter=0.
  - Outputs equal the FETCH decode with mem_ready=0: Mem_Read=1, ALU_Src_B=01, ALU_Control=010, all others 0.
- Cycles with zero wait states: lw 5; sw, R-type and addi 4; beq, bne and j 3. Each wait cycle adds 1.
- mem_ready is sampled only in FETCH/MEMRD/MEMWR and is ignored elsewhere.
- Reset mid-access: strobes drop immediately and no write completes.

## Configuration
- MC_CTRL_BNE_EN defined: Op 0x05 in DECODE goes to BNEEX.
- MC_CTRL_BNE_EN undefined: Op 0x05 goes to TRAP with Illegal=1, and state code 12 is unreachable.

## Test plan
- Reset low, then high with mem_ready=1 and lw (0x23): State sequence 0,1,2,3,4,0. Reg_Write=1 with Mem_to_Reg=1 in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR: Mem_Write stays 1 for 4 cycles, then FETCH. Illegal=0, Timeout=0.
- beq with Zero=1 then Zero=0: PC_En=1 in BEQEX for the first and 0 for the second. PC_Src=01 in both.
- R-type Funct 0x2A -> ALU_Control=111 and ALUWB Reg_Dst=1. Funct 0x3F -> State=15, Illegal=1, all strobes 0.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: TRAP after 5 cycles with Timeout=1. Reset low clears it to FETCH.
- Op 0x05 with Zero=0: PC_En=1 in State 12 when MC_CTRL_BNE_EN is defined; Illegal=1 when undefined.
